sd_block_writer: RTL
====================

# sd_block_writer

Streams bytes into the SD card through the write port of the existing `sd_controller`, the write-direction counterpart of the audio read path. It accepts an 8-bit valid/ready stream, packs it into 512-byte blocks in a two-bank (ping-pong) buffer, and issues one `sd_controller` write per full block. It sits between a byte producer (for example an 8-bit audio sample source) and `sd_controller`, and shares the 25 MHz SD clock domain.

## Interface

**Parameters**
- `START_ADDR`, default 0: byte address of the first block. Must be a multiple of 512.
- `PAD_BYTE`, default 8'h80: fill value used when flushing a partial block (unsigned-audio silence).

**Ports**
- `clk_in` input 1: single clock, the 25 MHz SD clock. One clock.
- `rst_n_in` input 1: reset, asynchronous and active-low.
- `data_in` input 8: stream byte.
- `data_valid_in` input 1: `data_in` valid.
- `data_ready_out` output 1: a byte is accepted on any cycle where valid and ready are both high.
- `flush_in` input 1: pulse; pad the current partial block to 512 bytes and commit it.
- `sd_ready_in` input 1: `sd_controller` ready.
- `sd_rfnb_in` input 1: `sd_controller` ready_for_next_byte.
- `sd_wr_out` output 1: write request to `sd_controller`.
- `sd_address_out` output 32: block byte address.
- `sd_din_out` output 8: byte presented to `sd_controller`.
- `busy_out` output 1: high when any bank is full, a write is in progress, or a flush is pending.
- `blocks_written_out` output 16: count of completed block writes. Wraps modulo 2^16.

## Operation

- Two banks of 512 bytes each. Each bank has a `full` flag.
  - The fill side owns one bank and keeps a 9-bit fill pointer.
  - The drain side owns the other bank.
- **Fill:** each accepted byte goes to `bank[fill][ptr]` and `ptr` increments.
  - When the byte at `ptr == 511` is accepted, the bank is marked full and `fill` toggles.
  - If the newly selected bank is still full, `data_ready_out` stays low until that bank is released.
- **Flush:**
  - `flush_in` sets `flush_pending`.
  - When the fill bank is writable, `PAD_BYTE` is written at one byte per cycle until the bank is full. `data_ready_out` is low during padding.
  - If a byte is accepted in the same cycle as `flush_in`, that byte is stored first.
  - If a flush arrives while `ptr == 0`, it is a no-op: no empty block is written.
- **Drain FSM:**
  - IDLE: if `bank[drain].full`, go to WAIT_RDY.
  - WAIT_RDY: wait for `sd_ready_in == 1`, then go to ISSUE.
  - ISSUE: `sd_wr_out = 1`. Hold until the first cycle with `sd_ready_in == 0`, then go to XFER.
  - XFER: consume one byte on each rising edge of `sd_rfnb_in` (high now, low in the previous cycle). After the 512th edge, go to DONE.
  - DONE: wait for `sd_ready_in == 1`. Then clear `bank[drain].full`, toggle `drain`, add 512 to `sd_address_out`, increment `blocks_written_out`, and return to IDLE.
- `sd_din_out` is a register that is prefetched before ISSUE with byte 0 of the drain bank. After each consume edge it is reloaded with the next byte. Reload latency is 2 cycles, which is far shorter than the SPI byte time.
- Address arithmetic is 32-bit unsigned and wraps silently.

## Timing

- **Reset values:**
  - `data_ready_out` = 0. It goes to 1 on the first cycle after reset deassertion.
  - `sd_wr_out` = 0.
  - `sd_address_out` = `START_ADDR`.
  - `sd_din_out` = 0.
  - `busy_out` = 0.
  - `blocks_written_out` = 0.
  - Both `full` flags cleared, `ptr` = 0, `fill` = 0, `drain` = 0, FSM in IDLE.
- **Reset mid-transfer:** everything above is re-initialized immediately, including any data held in the banks. `sd_controller` is reset by the same reset.
- **Drain start latency:** IDLE→WAIT_RDY takes 1 cycle after `full` is set. ISSUE is entered no earlier than 2 cycles after the 512th byte is accepted.
- **Simultaneous release and fill:** a bank released in DONE may be selected for filling on the next cycle.
- **Redundant `sd_rfnb_in` edges:** edges seen outside XFER are ignored.

## Structure

- **Package `sd_writer_pkg`:**
  - `drain_state_t` enum (IDLE, WAIT_RDY, ISSUE, XFER, DONE).
  - `BLOCK_BYTES = 512`.
  - `BLOCK_PTR_W = 9`.
- **Sub-module `sd_block_buffer`:** 1024×8 simple dual-port RAM with one write port and one synchronous read port (1-cycle latency). The address is {bank, ptr}.

## Test plan

- Reset, then stream 512 bytes 0..255,0..255 with a stubbed controller → one write at address 0 with those bytes in order, and `blocks_written_out` = 1.
- Stream 1536 bytes continuously while the stub consumes slowly → `data_ready_out` drops while both banks are full, and addresses 0, 512, 1024 are written in order.
- Send 100 bytes, then `flush_in` → block carries 100 data bytes followed by 412 × 8'h80. A second flush with `ptr = 0` produces no write.
- Assert `flush_in` in the same cycle as an accepted byte → that byte is at its index, with padding after it.
- Assert `rst_n_in` low in XFER at byte 200 → all outputs return to their reset values asynchronously, and the next write targets `START_ADDR`.
- Set `START_ADDR` = 32'hFFFF_FE00 and write 2 blocks → the second block's address wraps to 0.

Source files
------------

// File: rtl/sd_writer_pkg.sv
// sd_writer_pkg: shared types and sizes for the SD block writer.
// Drain FSM state encoding and block geometry.
package sd_writer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      ISSUE,
      XFER,
      DONE
   } drain_state_t;

   localparam int BLOCK_BYTES = 512;
   localparam int BLOCK_PTR_W = 9;

endpackage

// File: rtl/sd_block_buffer.sv
// sd_block_buffer: 1024x8 simple dual-port RAM, two 512-byte banks.
// Ports: write (wr_en_in, wr_addr_in, wr_data_in); read (rd_addr_in -> rd_data_out, 1-cycle).
module sd_block_buffer
   import sd_writer_pkg::*;
(
   input  logic                 clk_in,
   input  logic                 wr_en_in,
   input  logic [BLOCK_PTR_W:0] wr_addr_in,
   input  logic [7:0]           wr_data_in,
   input  logic [BLOCK_PTR_W:0] rd_addr_in,
   output logic [7:0]           rd_data_out
);

   logic [7:0] mem [2*BLOCK_BYTES];

   always_ff @(posedge clk_in) begin
      if (wr_en_in) mem[wr_addr_in] <= wr_data_in;
      rd_data_out <= mem[rd_addr_in];
   end

endmodule

// File: rtl/sd_block_writer.sv
// sd_block_writer: packs an 8-bit valid/ready stream into 512-byte blocks
// in a ping-pong buffer and issues one sd_controller write per full block.
// Ports: clk_in/rst_n_in; stream data_in/data_valid_in/data_ready_out;
// flush_in; sd_controller side sd_ready_in/sd_rfnb_in/sd_wr_out/
// sd_address_out/sd_din_out; status busy_out/blocks_written_out.
module sd_block_writer
   import sd_writer_pkg::*;
#(
   parameter logic [31:0] START_ADDR = 32'd0,
   parameter logic [7:0]  PAD_BYTE   = 8'h80
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [7:0]  data_in,
   input  logic        data_valid_in,
   output logic        data_ready_out,
   input  logic        flush_in,
   input  logic        sd_ready_in,
   input  logic        sd_rfnb_in,
   output logic        sd_wr_out,
   output logic [31:0] sd_address_out,
   output logic [7:0]  sd_din_out,
   output logic        busy_out,
   output logic [15:0] blocks_written_out
);

   localparam logic [BLOCK_PTR_W-1:0] LAST = BLOCK_PTR_W'(BLOCK_BYTES - 1);

   drain_state_t state, state_nx;

   logic                   rst_done;
   logic                   fill;
   logic                   drain;
   logic [1:0]             full;
   logic                   flush_pending;
   logic [BLOCK_PTR_W-1:0] ptr;
   logic [BLOCK_PTR_W-1:0] rd_ptr;
   logic [BLOCK_PTR_W-1:0] xcnt;
   logic                   pf1;
   logic                   pf2;
   logic                   rfnb_q;
   logic [7:0]             rdata;

   logic                   fill_open;
   logic                   accept;
   logic                   pad_now;
   logic                   buf_we;
   logic [7:0]             buf_wd;
   logic                   last_wr;
   logic                   consume;
   logic                   release_bank;
   logic                   start_pf;
   logic [1:0]             set_mask;
   logic [1:0]             clr_mask;

   // Fill side: stream bytes, or pad bytes while a flush is pending.
   assign fill_open      = rst_done && !full[fill];
   assign data_ready_out = fill_open && !flush_pending;
   assign accept         = data_valid_in && data_ready_out;
   assign pad_now        = fill_open && flush_pending && (ptr != '0);
   assign buf_we         = accept || pad_now;
   assign buf_wd         = accept ? data_in : PAD_BYTE;
   assign last_wr        = buf_we && (ptr == LAST);

   // Drain side: only rfnb rising edges inside XFER count.
   assign consume      = (state == XFER) && sd_rfnb_in && !rfnb_q;
   assign release_bank = (state == DONE) && sd_ready_in;
   assign start_pf     = (state == IDLE) && full[drain];

   assign set_mask = last_wr      ? (2'b01 << fill)  : 2'b00;
   assign clr_mask = release_bank ? (2'b01 << drain) : 2'b00;

   assign sd_wr_out = (state == ISSUE);
   assign busy_out  = (|full) || (state != IDLE) || flush_pending;

   sd_block_buffer u_buf (
      .clk_in      (clk_in),
      .wr_en_in    (buf_we),
      .wr_addr_in  ({fill, ptr}),
      .wr_data_in  (buf_wd),
      .rd_addr_in  ({drain, rd_ptr}),
      .rd_data_out (rdata)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rst_done      <= 1'b0;
         fill          <= 1'b0;
         ptr           <= '0;
         full          <= 2'b00;
         flush_pending <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         full     <= (full | set_mask) & ~clr_mask;
         if (buf_we) ptr <= ptr + 1'b1;
         if (last_wr) fill <= ~fill;
         // A flush at ptr == 0 has nothing to pad and just retires.
         if (flush_in) flush_pending <= 1'b1;
         else if (pad_now && last_wr) flush_pending <= 1'b0;
         else if (flush_pending && ptr == '0) flush_pending <= 1'b0;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (full[drain]) state_nx = WAIT_RDY;
         // Hold off the request until byte 0 sits in sd_din_out.
         WAIT_RDY: if (sd_ready_in && !pf1 && !pf2) state_nx = ISSUE;
         ISSUE:    if (!sd_ready_in) state_nx = XFER;
         XFER:     if (consume && xcnt == LAST) state_nx = DONE;
         DONE:     if (sd_ready_in) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state              <= IDLE;
         drain              <= 1'b0;
         rd_ptr             <= '0;
         xcnt               <= '0;
         pf1                <= 1'b0;
         pf2                <= 1'b0;
         rfnb_q             <= 1'b0;
         sd_din_out         <= 8'h00;
         sd_address_out     <= START_ADDR;
         blocks_written_out <= 16'h0000;
      end else begin
         state  <= state_nx;
         rfnb_q <= sd_rfnb_in;
         // Two-stage reload: RAM read, then load the output register.
         pf1 <= start_pf || (consume && xcnt != LAST);
         pf2 <= pf1;
         if (pf2) sd_din_out <= rdata;
         if (consume) begin
            xcnt <= xcnt + 1'b1;
            if (xcnt != LAST) rd_ptr <= rd_ptr + 1'b1;
         end
         if (release_bank) begin
            drain              <= ~drain;
            rd_ptr             <= '0;
            xcnt               <= '0;
            sd_address_out     <= sd_address_out + 32'(BLOCK_BYTES);
            blocks_written_out <= blocks_written_out + 16'd1;
         end
      end
   end

endmodule
